// File: rtl/nn_reset_pkg.sv
// Shared types and helpers for the reset sequencer.
package nn_reset_pkg;

  // Legal range for the number of sequenced stage resets.
  localparam int unsigned NUM_STAGES_MIN = 1;
  localparam int unsigned NUM_STAGES_MAX = 16;

  typedef enum logic [1:0] {
    StHold,
    StRelease,
    StReady
  } seq_state_e;

  // Counter must be able to hold the larger of the two match values.
  function automatic int unsigned cnt_width(int unsigned hold, int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nn_rise_detect.sv
// Rising-edge detector with a registered history bit and synchronous active-high reset.
module nn_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Remember the previous sample of din.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  // Rise is combinational on din so the consumer can act on the same edge.
  assign rise = din & ~din_q;

endmodule

// File: rtl/nn_reset_sequencer.sv
// Staggered per-stage reset release with optional soft re-sequence.
// Build option: define NN_RESET_SEQ_SOFT_EN to compile in the soft_req / soft_ack path.
module nn_reset_sequencer
  import nn_reset_pkg::*;
#(
  parameter int unsigned NUM_STAGES       = 4,
  parameter int unsigned HOLD_CYCLES      = 16,
  parameter int unsigned STAGE_GAP_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  soft_req,
  output logic                  soft_ack,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_ready
);

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, STAGE_GAP_CYCLES);

  if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_num_stages
    $error("NUM_STAGES out of range");
  end

  seq_state_e            state_q;
  logic [CntW-1:0]       cnt_q;
  logic [CntW-1:0]       cnt_inc;
  logic [NUM_STAGES-1:0] stage_reset_q;
  logic [NUM_STAGES-1:0] stage_shift;
  logic                  all_ready_q;

  assign cnt_inc = cnt_q + CntW'(1);
  // Shifting in a zero clears the lowest still-set bit, so bits release in index order.
  assign stage_shift = stage_reset_q << 1;

`ifdef NN_RESET_SEQ_SOFT_EN
  logic soft_rise;
  logic soft_ack_q;

  nn_rise_detect u_soft_rise (
    .clk   (clk),
    .reset (reset),
    .din   (soft_req),
    .rise  (soft_rise)
  );

  assign soft_ack = soft_ack_q;
`else
  logic unused_soft_req;
  assign unused_soft_req = soft_req;
  assign soft_ack        = 1'b0;
`endif

  // Sequencer FSM; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StHold;
      cnt_q         <= '0;
      stage_reset_q <= '1;
      all_ready_q   <= 1'b0;
`ifdef NN_RESET_SEQ_SOFT_EN
      soft_ack_q    <= 1'b0;
`endif
    end else begin
`ifdef NN_RESET_SEQ_SOFT_EN
      soft_ack_q <= 1'b0;
`endif
      unique case (state_q)
        StHold: begin
          if (cnt_inc == CntW'(HOLD_CYCLES)) begin
            cnt_q         <= '0;
            stage_reset_q <= stage_shift;
            state_q       <= (stage_shift == '0) ? StReady : StRelease;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StRelease: begin
          if (cnt_inc == CntW'(STAGE_GAP_CYCLES)) begin
            cnt_q         <= '0;
            stage_reset_q <= stage_shift;
            if (stage_shift == '0) begin
              state_q <= StReady;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StReady: begin
          all_ready_q <= 1'b1;
`ifdef NN_RESET_SEQ_SOFT_EN
          if (soft_rise) begin
            soft_ack_q    <= 1'b1;
            stage_reset_q <= '1;
            all_ready_q   <= 1'b0;
            cnt_q         <= '0;
            state_q       <= StHold;
          end
`endif
        end
        default: begin
          state_q <= StHold;
        end
      endcase
    end
  end

  assign stage_reset = stage_reset_q;
  assign all_ready   = all_ready_q;

endmodule

// File: doc/nn_reset_sequencer.md
# nn_reset_sequencer

Consumes the power-on reset produced by the design's reset source and turns it into an ordered, staggered set of per-stage resets, releasing each stage a fixed number of cycles after the previous one. It also accepts a soft-reset request that re-runs the full sequence without a power cycle. It sits directly downstream of the reset source and drives the reset inputs of the pipeline stages in release order.

## Interface
- NUM_STAGES, 4, number of stage resets; legal 1..16
- HOLD_CYCLES, 16, cycles all stages are held in reset after `reset` deasserts; legal ≥1
- STAGE_GAP_CYCLES, 8, cycles between consecutive stage releases; legal ≥1
- clk  in  1  single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high; driven by the reset source
- soft_req  in  1  soft-reset request; a rising edge requests a re-sequence
- soft_ack  out  1  one-cycle pulse; soft request accepted
- stage_reset  out  NUM_STAGES  active-high reset per stage; bit 0 is released first
- all_ready  out  1  high once every stage is released

## Operation
- Reset values (edge where `reset`=1): stage_reset all ones, all_ready 0, soft_ack 0, state HOLD, counter 0, soft_req history register 0.
- States:
  - HOLD: all stage_reset bits are 1. The counter increments once per cycle. When the counter reaches HOLD_CYCLES, the block clears stage_reset[0], zeroes the counter, and moves to RELEASE. If NUM_STAGES=1, it goes to READY instead.
  - RELEASE: the counter increments once per cycle. Each time it reaches STAGE_GAP_CYCLES, the block clears the next stage bit and zeroes the counter. After the last bit clears, it moves to READY.
  - READY: all_ready=1 and stage_reset all zero. The state is held until a soft request or `reset`.
- Soft request:
  - A rising edge is detected as soft_req=1 while the registered previous soft_req=0.
  - The edge is accepted only in READY. On acceptance, the next edge sets soft_ack=1 for one cycle, sets stage_reset to all ones, sets all_ready=0, zeroes the counter, and enters HOLD.
  - A rising edge seen in HOLD or RELEASE is dropped, with no ack.
  - A level held high does not re-trigger.
- `reset` dominates everything. If it is asserted mid-sequence, the next edge returns the block to its reset values. If it coincides with a soft_req edge, there is no ack.
- Counter width is $clog2(max(HOLD_CYCLES, STAGE_GAP_CYCLES)+1). The counter never wraps, because it is zeroed on every match.
- stage_reset bits clear strictly in index order and never reassert except via `reset` or an accepted soft request.

## Timing
- Cycle numbering: cycle n is the n-th rising edge with `reset`=0 (n=1 is first).
- stage_reset[i] clears at cycle HOLD_CYCLES + i·STAGE_GAP_CYCLES.
- all_ready rises one cycle after stage_reset[NUM_STAGES-1] clears.
- Soft path: a soft_req edge is sampled at cycle k in READY. soft_ack is high in cycle k, the output of the same registered update. stage_reset is all ones from cycle k. The sequence then restarts, with cycle k+1 counting as HOLD cycle 1.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- NN_RESET_SEQ_SOFT_EN defined: the soft-request path, edge detector and soft_ack are compiled in as described above.
- NN_RESET_SEQ_SOFT_EN undefined: soft_req is ignored and soft_ack is tied 0. The ports remain, and READY is left only via `reset`.

## Structure
- Shared package nn_reset_pkg contains:
  - the state enum (HOLD, RELEASE, READY)
  - the counter-width function
  - the NUM_STAGES legal-range constants
- One sub-module, nn_rise_detect: registered rising-edge detector for soft_req with a synchronous active-high reset. It is instantiated only when NN_RESET_SEQ_SOFT_EN is defined.

## Test plan
All scenarios use default parameters unless stated.
- Power-on: hold `reset` for 3 cycles, then release. Required: stage_reset clears bit 0 at cycle 16, bit 1 at 24, bit 2 at 32, bit 3 at 40; all_ready rises at cycle 41.
- Mid-sequence reset: assert `reset` for 1 cycle at cycle 28. Required: stage_reset returns to 4'b1111 and all_ready is 0. After release, bit 0 clears 16 cycles later.
- Soft request in READY: raise soft_req at cycle 50 and hold it for 10 cycles. Required: a single soft_ack pulse at cycle 50, stage_reset=4'b1111, and the sequence reruns with all_ready at cycle 91.
- Soft request during RELEASE: pulse soft_req at cycle 20. Required: no soft_ack and an unchanged release schedule.
- Corner parameters NUM_STAGES=1, HOLD_CYCLES=1: stage_reset[0] clears at cycle 1 and all_ready is high at cycle 2.
- Macro undefined: soft_req edges in READY produce no ack and all_ready stays high.
